// File: rtl/decoder_in_conditioner.sv
// -----------------------------------------------------------------------------
// decoder_in_conditioner
//
// Input-conditioning stage in front of decoder_proj. The raw pad bus is
// synchronized, debounced, and each newly stable code is queued once in a
// small FIFO. The decoder drains the FIFO through a valid/ready handshake.
// As a result the decoder never sees metastable, glitching or repeated codes.
//
// Parameters:
//   WIDTH    - code width; matches the decoder io_in
//   DEBOUNCE - consecutive stable cycles required before a commit (>= 1)
//   DEPTH    - FIFO entries; power of two, >= 2
//
// Ports:
//   clk            in   sole clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   io_in          in   raw asynchronous pad inputs
//   code_o         out  FIFO head code (0 while empty)
//   code_valid_o   out  FIFO non-empty
//   code_ready_i   in   decoder accepts the head this cycle
//   level_o        out  current FIFO occupancy
//   overflow_o     out  sticky: a committed code was dropped on a full FIFO
//   overflow_clr_i in   synchronous clear of overflow_o (a new drop wins)
// -----------------------------------------------------------------------------
module decoder_in_conditioner #(
   parameter int WIDTH    = 7,
   parameter int DEBOUNCE = 4,
   parameter int DEPTH    = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           io_in,
   output logic [WIDTH-1:0]           code_o,
   output logic                       code_valid_o,
   input  logic                       code_ready_i,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       overflow_o,
   input  logic                       overflow_clr_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEBOUNCE + 1);

   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE);
   localparam logic [CW-1:0] CNT_COMMIT = CW'(DEBOUNCE - 1);
   localparam logic [AW:0]   PTR_ONE    = (AW + 1)'(1);
   localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);

   // ---------------------------------------------------------------------------
   // Two-flop synchronizer, one independent chain per bit
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its source, regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= io_in;
         s2 <= s1;
      end
   end

   // ---------------------------------------------------------------------------
   // Debounce: cand tracks the latest s2 value, cnt counts stable edges
   // since cand was loaded and saturates at DEBOUNCE.
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] cand;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] last;
   logic             commit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand <= '0;
         cnt  <= '0;
      end else if (s2 != cand) begin
         cand <= s2;
         cnt  <= '0;
      end else if (cnt < CNT_MAX) begin
         cnt  <= cnt + CNT_ONE;
      end
   end

   // The strobe fires on the single edge where cnt would step past
   // DEBOUNCE-1, so a saturated counter never re-commits. Comparing with
   // last suppresses repeats, including the reset value 0.
   assign commit = (s2 == cand) && (cnt == CNT_COMMIT) && (cand != last);

   // last follows every commit, even one dropped by a full FIFO, so the
   // same code is not retried once space frees up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= '0;
      end else if (commit) begin
         last <= cand;
      end
   end

   // ---------------------------------------------------------------------------
   // FIFO: pointers carry one extra wrap bit so full and empty are distinct
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             full;
   logic             rd_en;
   logic             wr_en;
   logic             drop;

   assign level_o      = wr_ptr - rd_ptr;
   assign code_valid_o = (level_o != '0);
   assign full         = (level_o == LEVEL_FULL);
   assign rd_en        = code_valid_o && code_ready_i;
   // A read on the same edge frees the slot the write needs.
   assign wr_en        = commit && (!full || rd_en);
   assign drop         = commit && full && !rd_en;

   // Gating with valid keeps code_o at 0 while empty, including after reset,
   // without needing to clear the storage.
   assign code_o = code_valid_o ? mem[rd_ptr[AW-1:0]] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // NOTE: storage has no reset; entries are only observable between the
   // pointers, and those are cleared, so resetting the array would buy nothing.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= cand;
      end
   end

   // ---------------------------------------------------------------------------
   // Sticky overflow flag; a drop on the same edge as a clear keeps it set
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_o <= 1'b0;
      end else if (drop) begin
         overflow_o <= 1'b1;
      end else if (overflow_clr_i) begin
         overflow_o <= 1'b0;
      end
   end

endmodule

// File: doc/decoder_in_conditioner.md
# decoder_in_conditioner

Input-conditioning stage directly upstream of `decoder_proj`. It synchronizes the raw 7-bit pad bus, debounces it, and turns each newly stable code into one entry in a small FIFO. The decoder consumes these entries through a valid/ready handshake. This guarantees the decoder never sees metastable, glitching or repeated codes.

## Interface
- `WIDTH`, 7: code width; matches decoder `io_in`.
- `DEBOUNCE`, 4: consecutive stable cycles required before commit; must be ≥1.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk`  in  1  sole clock; all flops rise-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `io_in`  in  WIDTH  raw asynchronous pad inputs.
- `code_o`  out  WIDTH  FIFO head code to the decoder.
- `code_valid_o`  out  1  FIFO non-empty.
- `code_ready_i`  in  1  decoder accepts the head this cycle.
- `level_o`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overflow_o`  out  1  sticky flag: a committed code was dropped.
- `overflow_clr_i`  in  1  synchronous clear of `overflow_o`.

## Operation
- **Reset** (async assert, sync release by the system). The following all clear to 0: sync flops, candidate `cand`, counter `cnt`, committed code `last`, FIFO pointers. As a result:
  - `code_o` = 0, `code_valid_o` = 0, `level_o` = 0, `overflow_o` = 0.
  - Asserting reset mid-operation discards all FIFO contents and the debounce state.
- **Synchronizer.** Two flops per bit (`s1`→`s2`), no bit-level combining ahead of them.
- **Debounce**, evaluated every edge:
  - If `s2` ≠ `cand`: `cand` ← `s2`, `cnt` ← 0.
  - Else if `cnt` < `DEBOUNCE`: `cnt` ← `cnt`+1.
  - `cnt` saturates at `DEBOUNCE`; its width is $clog2(DEBOUNCE+1).
- **Commit** (combinational strobe): `s2` == `cand`, `cnt` == `DEBOUNCE`−1, and `cand` ≠ `last`.
  - On the commit edge, `last` ← `cand` and a FIFO write is requested.
  - A code equal to `last` never commits, so the reset-value 0 generates no entry.
  - Returning to an earlier code (A→B→A) does commit, because `last` has changed.
- **FIFO**, circular, DEPTH entries, with read/write pointers one bit wider than the address.
  - Read happens when `code_valid_o` && `code_ready_i`; `code_o` is the head entry, driven combinationally from storage.
  - Write is accepted if not full, or if full with a read in the same cycle.
  - When full with no read, the commit is dropped: storage is unchanged, `overflow_o` ← 1, and `last` is still updated.
  - Simultaneous read and write keeps `level_o` unchanged.
  - There is no empty bypass: a write into an empty FIFO shows `code_valid_o` on the next cycle.
- **Overflow flag.** `overflow_clr_i` clears it. If a clear and a new overflow occur on the same edge, set wins.
- **Handshake rules.** `code_o` is held stable while `code_valid_o`=1 and `code_ready_i`=0. `code_ready_i` while empty has no effect.

## Timing
- Consider a change on `io_in` held stable before edge E1:
  - `s2` updates at E2.
  - `cand` updates at E3 with `cnt`=0.
  - Commit and write occur at edge E(3+DEBOUNCE).
  - `code_valid_o`/`code_o` are valid after that edge.
- Total latency is DEBOUNCE+3 edges (7 at default).
- Any input toggle inside the window restarts the count from the edge where `s2` differs.
- A pulse shorter than DEBOUNCE+1 cycles at `s2` never commits.
- Read-to-next-head: `code_o` advances on the edge where the handshake completes.
- Maximum sustained throughput is one code per DEBOUNCE+1 cycles, well below the drain rate of one entry per cycle.

## Test plan
- **Basic commit.** After reset, drive `io_in`=7'b1010100 and hold. Expect `code_valid_o`=0 through edge 6 and `code_valid_o`=1 with `code_o`=7'b1010100 after edge 7. With `code_ready_i`=1 for one cycle, `level_o` returns to 0 and valid drops.
- **Glitch reject.** From committed 7'h54, pulse `io_in`=7'h55 for 3 cycles, then return to 7'h54. Expect no FIFO write and `level_o`=0. A second pulse held for 5 cycles commits 7'h55, then 7'h54 commits afterwards.
- **Overflow.** With `code_ready_i`=0, commit 5 distinct codes (01, 02, 03, 04, 05). Expect `level_o`=4 and `overflow_o`=1. The draining order is 01, 02, 03, 04, and 05 is lost.
- **Full plus simultaneous read.** With the FIFO full, assert `code_ready_i` on the commit edge. Expect the write to be accepted, `level_o`=4 and `overflow_o` unchanged.
- **Flag clear race.** Assert `overflow_clr_i` on the same edge as a new drop. Expect `overflow_o` to stay 1; a clear alone then gives 0.
- **Reset mid-operation.** With 3 entries queued and a debounce in progress, pulse `rst_n` low asynchronously between edges. Expect all outputs 0 immediately. Re-applying the same input commits it again after 7 edges.
